input_setup: RTL and testbench
==============================

// Module: input_setup
// PURPOSE
// - Consumes the 2x2 activation tile the unified buffer returns on a load_input read
//   (out_ub_00/01/10/11) and streams it diagonally skewed into the 2x2 systolic array.
// - Row 0 leads row 1 by one cycle. A one-deep pending slot lets the controller issue
//   the next tile while the current one is still streaming.
// PARAMETERS
// - DATA_W  32  width of every activation word (matches the unified buffer word width)
// PORTS
// - clk         in   1       rising-edge clock
// - reset       in   1       synchronous, active-high
// - load        in   1       tile strobe; in_* are valid this cycle (one cycle after UB load_input)
// - in_00       in   DATA_W  tile element row0,col0
// - in_01       in   DATA_W  tile element row0,col1
// - in_10       in   DATA_W  tile element row1,col0
// - in_11       in   DATA_W  tile element row1,col1
// - ready       out  1       pending slot empty (= !pend_v, combinational)
// - row0_out    out  DATA_W  activation into array row 0
// - row0_valid  out  1       row0_out carries data
// - row1_out    out  DATA_W  activation into array row 1
// - row1_valid  out  1       row1_out carries data
// - busy        out  1       state != IDLE
// - tile_done   out  1       1-cycle pulse, coincident with the last element (x11) on row1_out
// - overflow    out  1       sticky; a load was dropped; cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE, pend_v=0; every registered output (row*_out, row*_valid, tile_done,
//   overflow) is 0 on the next edge. Reset mid-stream abandons the active and pending tiles.
// - States IDLE, S1, S2, S3 (S = phase currently visible on the outputs). All outputs registered.
// - Phase drive for active tile x (written at the edge that enters the state):
//   S1: row0=x00 v0=1 | row1=0 v1=0
//   S2: row0=x01 v0=1 | row1=x10 v1=1
//   S3: row0=0 v0=0   | row1=x11 v1=1 | tile_done=1
// - Latency: load sampled at edge E -> x00 visible in the cycle after E.
//   A lone tile occupies exactly 3 output cycles.
// - Transitions:
//   - IDLE: load -> capture into active, enter S1; otherwise outputs stay 0.
//   - S1 -> S2 -> S3 unconditionally.
//   - S3 (next edge): if pend_v, promote pending to active and enter S1. Otherwise, if load,
//     capture directly into active and enter S1. Otherwise zero the outputs and go to IDLE.
//     Back-to-back tiles have no bubble cycle.
// - load in S1/S2: pend_v=0 -> capture into pending and set pend_v. pend_v=1 -> drop the tile
//   and set overflow.
// - load in S3 with pend_v=1: pending promotes to active and the new tile refills pending
//   (no drop). load in S3 with pend_v=0: the new tile starts directly; pending stays empty.
// - load in IDLE never touches pending. Data pass through unmodified; no arithmetic.
// CONFIGURATION
// - INPUT_SETUP_TRANSPOSE_EN defined: at capture (active or pending) in_01 and in_10 are swapped,
//   so the array receives the transposed tile: S2 row0=x10, row1=x01. Nothing else changes.
// - Not defined: tile is streamed as given (default build).
// TESTING
// - Single tile: load with 11/12/21/22 -> next 3 cycles row0=11,12,0 (v 1,1,0);
//   row1=0,21,22 (v 0,1,1); tile_done in the 3rd cycle; busy high for 3 cycles, then IDLE.
// - Back-to-back: tile A (11,12,21,22), then tile B (31,32,41,42) during A's S1 ->
//   ready drops; B's 31 appears on row0 the cycle after A's 22; 6 contiguous output cycles.
// - Overflow: three loads within A's S1/S2 -> third tile dropped, overflow=1 and stays set
//   until reset; A and B stream intact.
// - Load in S3 with pend_v=1: A streaming, B pending, C strobed in A's S3 -> B starts next,
//   C held in pending, overflow stays 0; C follows B with no bubble.
// - Reset mid-stream: reset asserted during S2 with a pending tile -> next cycle all outputs 0,
//   ready=1, busy=0; a fresh load then streams normally.
// - Transpose build: with INPUT_SETUP_TRANSPOSE_EN, tile 11/12/21/22 -> S2 row0=21, row1=12.

Source files
------------

// File: rtl/input_setup.sv
// Skews a 2x2 activation tile diagonally into the systolic array rows.
// Optional INPUT_SETUP_TRANSPOSE_EN swaps x01/x10 at capture.
module input_setup #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_00,
  input  logic [DATA_W-1:0] in_01,
  input  logic [DATA_W-1:0] in_10,
  input  logic [DATA_W-1:0] in_11,
  output logic              ready,
  output logic [DATA_W-1:0] row0_out,
  output logic              row0_valid,
  output logic [DATA_W-1:0] row1_out,
  output logic              row1_valid,
  output logic              busy,
  output logic              tile_done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2,
    S3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] cap_00, cap_01, cap_10, cap_11;
  logic [DATA_W-1:0] act_00_q, act_01_q, act_10_q, act_11_q;
  logic [DATA_W-1:0] act_00_d, act_01_d, act_10_d, act_11_d;
  logic [DATA_W-1:0] pnd_00_q, pnd_01_q, pnd_10_q, pnd_11_q;
  logic [DATA_W-1:0] pnd_00_d, pnd_01_d, pnd_10_d, pnd_11_d;
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] r0_q, r0_d, r1_q, r1_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  assign cap_00 = in_00;
  assign cap_11 = in_11;
`ifdef INPUT_SETUP_TRANSPOSE_EN
  assign cap_01 = in_10;
  assign cap_10 = in_01;
`else
  assign cap_01 = in_01;
  assign cap_10 = in_10;
`endif

  always_comb begin
    state_d  = state_q;
    act_00_d = act_00_q;
    act_01_d = act_01_q;
    act_10_d = act_10_q;
    act_11_d = act_11_q;
    pnd_00_d = pnd_00_q;
    pnd_01_d = pnd_01_q;
    pnd_10_d = pnd_10_q;
    pnd_11_d = pnd_11_q;
    pend_v_d = pend_v_q;
    r0_d     = '0;
    v0_d     = 1'b0;
    r1_d     = '0;
    v1_d     = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    // Mid-stream loads fill the pending slot or are dropped.
    if (load && (state_q == S1 || state_q == S2)) begin
      if (!pend_v_q) begin
        pnd_00_d = cap_00;
        pnd_01_d = cap_01;
        pnd_10_d = cap_10;
        pnd_11_d = cap_11;
        pend_v_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (load) begin
          act_00_d = cap_00;
          act_01_d = cap_01;
          act_10_d = cap_10;
          act_11_d = cap_11;
          r0_d     = cap_00;
          v0_d     = 1'b1;
          state_d  = S1;
        end
      end
      S1: begin
        r0_d    = act_01_q;
        v0_d    = 1'b1;
        r1_d    = act_10_q;
        v1_d    = 1'b1;
        state_d = S2;
      end
      S2: begin
        r1_d    = act_11_q;
        v1_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S3;
      end
      S3: begin
        if (pend_v_q) begin
          act_00_d = pnd_00_q;
          act_01_d = pnd_01_q;
          act_10_d = pnd_10_q;
          act_11_d = pnd_11_q;
          r0_d     = pnd_00_q;
          v0_d     = 1'b1;
          state_d  = S1;
          pend_v_d = load;
          if (load) begin
            pnd_00_d = cap_00;
            pnd_01_d = cap_01;
            pnd_10_d = cap_10;
            pnd_11_d = cap_11;
          end
        end else if (load) begin
          act_00_d = cap_00;
          act_01_d = cap_01;
          act_10_d = cap_10;
          act_11_d = cap_11;
          r0_d     = cap_00;
          v0_d     = 1'b1;
          state_d  = S1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      act_00_q <= '0;
      act_01_q <= '0;
      act_10_q <= '0;
      act_11_q <= '0;
      pnd_00_q <= '0;
      pnd_01_q <= '0;
      pnd_10_q <= '0;
      pnd_11_q <= '0;
      pend_v_q <= 1'b0;
      r0_q     <= '0;
      v0_q     <= 1'b0;
      r1_q     <= '0;
      v1_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_00_q <= act_00_d;
      act_01_q <= act_01_d;
      act_10_q <= act_10_d;
      act_11_q <= act_11_d;
      pnd_00_q <= pnd_00_d;
      pnd_01_q <= pnd_01_d;
      pnd_10_q <= pnd_10_d;
      pnd_11_q <= pnd_11_d;
      pend_v_q <= pend_v_d;
      r0_q     <= r0_d;
      v0_q     <= v0_d;
      r1_q     <= r1_d;
      v1_q     <= v1_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready      = !pend_v_q;
  assign busy       = (state_q != IDLE);
  assign row0_out   = r0_q;
  assign row0_valid = v0_q;
  assign row1_out   = r1_q;
  assign row1_valid = v1_q;
  assign tile_done  = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_input_setup.sv
// Randomized and directed bench for input_setup.
// Reference: tile queue plus output-cycle counter.
module tb_input_setup;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] in_00, in_01, in_10, in_11;
  logic         ready;
  logic [W-1:0] row0_out, row1_out;
  logic         row0_valid, row1_valid;
  logic         busy, tile_done, overflow;

  input_setup #(.DATA_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .in_00(in_00),
    .in_01(in_01),
    .in_10(in_10),
    .in_11(in_11),
    .ready(ready),
    .row0_out(row0_out),
    .row0_valid(row0_valid),
    .row1_out(row1_out),
    .row1_valid(row1_valid),
    .busy(busy),
    .tile_done(tile_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] e00, e01, e10, e11;
  } tile_t;

  int    checks = 0;
  int    errors = 0;
  tile_t cur;
  tile_t waitq[$];
  int    cyc_left = 0;
  bit    m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Array sees the transposed tile when the build option is on.
  function automatic tile_t seen(input tile_t t);
    tile_t s;
    s = t;
`ifdef INPUT_SETUP_TRANSPOSE_EN
    s.e01 = t.e10;
    s.e10 = t.e01;
`endif
    return s;
  endfunction

  // cyc_left counts the output cycles the current tile still owes.
  task automatic model_edge(input bit ld, input bit rs, input tile_t t);
    if (rs) begin
      waitq.delete();
      cyc_left = 0;
      m_ovf = 1'b0;
      return;
    end
    if (cyc_left > 0) cyc_left--;
    if (ld) begin
      if (cyc_left == 0 && waitq.size() == 0) begin
        cur = seen(t);
        cyc_left = 3;
        return;
      end
      if (waitq.size() == 0 || cyc_left == 0) waitq.push_back(seen(t));
      else m_ovf = 1'b1;
    end
    if (cyc_left == 0 && waitq.size() > 0) begin
      cur = waitq.pop_front();
      cyc_left = 3;
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e_r0, e_r1;
    logic e_v0, e_v1, e_done;
    int ph;
    ph = 4 - cyc_left;
    e_r0 = '0; e_r1 = '0;
    e_v0 = 1'b0; e_v1 = 1'b0; e_done = 1'b0;
    if (cyc_left != 0) begin
      case (ph)
        1: begin e_r0 = cur.e00; e_v0 = 1'b1; end
        2: begin
          e_r0 = cur.e01; e_v0 = 1'b1;
          e_r1 = cur.e10; e_v1 = 1'b1;
        end
        default: begin
          e_r1 = cur.e11; e_v1 = 1'b1; e_done = 1'b1;
        end
      endcase
    end
    chk("row0_out", row0_out, e_r0);
    chk("row0_valid", W'(row0_valid), W'(e_v0));
    chk("row1_out", row1_out, e_r1);
    chk("row1_valid", W'(row1_valid), W'(e_v1));
    chk("tile_done", W'(tile_done), W'(e_done));
    chk("busy", W'(busy), W'(cyc_left != 0));
    chk("ready", W'(ready), W'(waitq.size() == 0));
    chk("overflow", W'(overflow), W'(m_ovf));
  endtask

  task automatic step(input bit ld, input bit rs, input tile_t t);
    @(negedge clk);
    reset = rs;
    load = ld;
    in_00 = t.e00;
    in_01 = t.e01;
    in_10 = t.e10;
    in_11 = t.e11;
    @(posedge clk);
    model_edge(ld, rs, t);
    #1;
    check_outputs();
  endtask

  function automatic tile_t mk(input int a, b, c, d);
    tile_t t;
    t.e00 = W'(a); t.e01 = W'(b);
    t.e10 = W'(c); t.e11 = W'(d);
    return t;
  endfunction

  function automatic tile_t rnd();
    tile_t t;
    t.e00 = $urandom; t.e01 = $urandom;
    t.e10 = $urandom; t.e11 = $urandom;
    return t;
  endfunction

  tile_t ta, tb, tc, tz;

  initial begin
    ta = mk(11, 12, 21, 22);
    tb = mk(31, 32, 41, 42);
    tc = mk(51, 52, 61, 62);
    tz = mk(0, 0, 0, 0);
    reset = 1'b1;
    load = 1'b0;
    {in_00, in_01, in_10, in_11} = '0;

    step(0, 1, tz);
    step(0, 1, tz);
    step(0, 0, tz);

    // Single tile
    step(1, 0, ta);
    repeat (5) step(0, 0, tz);

    // Back-to-back
    step(1, 0, ta);
    step(1, 0, tb);
    repeat (7) step(0, 0, tz);

    // Overflow: third tile dropped
    step(1, 0, ta);
    step(1, 0, tb);
    step(1, 0, tc);
    repeat (7) step(0, 0, tz);

    // Load in S3 with pending tile
    step(1, 1, tz);
    step(1, 0, ta);
    step(1, 0, tb);
    step(0, 0, tz);
    step(1, 0, tc);
    repeat (9) step(0, 0, tz);

    // Reset mid-stream
    step(1, 0, ta);
    step(1, 0, tb);
    step(0, 1, tz);
    step(0, 0, tz);
    step(1, 0, tc);
    repeat (4) step(0, 0, tz);

    // Load arriving exactly in idle-bound S3 with empty pending
    step(1, 0, ta);
    step(0, 0, tz);
    step(0, 0, tz);
    step(1, 0, tb);
    repeat (4) step(0, 0, tz);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0, rnd());
    repeat (5) step(0, 0, tz);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
